msk_gadget_scheduler: RTL and testbench
=======================================

// Module: msk_gadget_scheduler
// PURPOSE
//  Shares one fixed-latency masked gadget pipeline (e.g. an HPC AND/XNOR lane,
//   d shares, count bits) among NREQ requesters.
//  Picks one requester per cycle round-robin, gated on fresh randomness, and
//   drives its two sharings into the gadget.
//  Tracks in-flight tags for LAT cycles and returns each result to its owner.
//  Sits between the round datapath slices and a single shared nonlinear gadget.
// PARAMETERS
//  d      2  number of shares per bit
//  count  1  bits per sharing bundle (bus width = count*d)
//  NREQ   4  number of requesters, 2..8
//  LAT    1  gadget latency in cycles, 1..8 (pipeline registers inside gadget)
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   NREQ          requester i has an operand pair
//  req_ready  out  NREQ          one-hot grant; transfer when valid&ready
//  req_ina    in   NREQ*count*d  operand A sharings, requester i at slice i
//  req_inb    in   NREQ*count*d  operand B sharings, requester i at slice i
//  rnd_valid  in   1             fresh randomness present at gadget input
//  rnd_ready  out  1             randomness consumed this cycle (=issue)
//  g_ina      out  count*d       gadget operand A
//  g_inb      out  count*d       gadget operand B
//  g_out      in   count*d       gadget result, LAT cycles after issue
//  rsp_valid  out  NREQ          one-hot: rsp_data belongs to requester i
//  rsp_data   out  count*d       result sharing (registered-free passthrough)
//  busy       out  1             any op in flight
// BEHAVIOUR
//  Reset (async, rst_n=0): req_ready=0, rnd_ready=0, rsp_valid=0, busy=0,
//   tag pipe cleared, RR pointer=0; g_ina/g_inb=0. Reset mid-op drops all
//   in-flight ops; no rsp_valid after release for them.
//  Issue: issue = rnd_valid & |req_valid. Grant = first req_valid at or after
//   pointer (cyclic). req_ready = grant when issue, else 0 (combinational,
//   never depends on req_ina/inb data). rnd_ready = issue.
//  Pointer: on issue, ptr <= (granted index + 1) mod NREQ; else hold.
//  Operand mux: AND-OR with one-hot grant, per share; shares never combined.
//   No issue -> g_ina=g_inb=0 (no stale sharing re-presented to gadget).
//  Tag pipe: LAT stages of {valid, one-hot owner}; stage0 loads issue/grant.
//   rsp_valid = last-stage owner when last-stage valid, else 0.
//   rsp_data = g_out when any rsp_valid, else 0.
//  Latency: op accepted in cycle t -> rsp_valid in cycle t+LAT.
//  Throughput: one op/cycle; no response backpressure (requester must sink).
//  busy = OR of all tag-stage valid bits.
//  Boundaries: rnd_valid=0 stalls all grants (no op without randomness);
//   single requester may issue every cycle; issue and response to the same
//   requester in one cycle are independent; pointer wraps NREQ-1 -> 0.
//  Glitch/leakage: grant and mux select come from control only; req_ready
//   must not be a function of any share bit.
// STRUCTURE
//  Header msk_sched_defs.vh: NREQ/LAT bounds, tag width, onehot helper macros.
//  Sub-module msk_rr_arbiter (NREQ, req, en, grant, ptr update); rest inline.
//  Gadget itself is external; this block holds only control + muxes.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 ops in flight, LAT=3 -> all outputs 0,
//    no rsp_valid in the 3 cycles after release.
//  2 Latency: NREQ=4 LAT=2, req_valid=0100, rnd_valid=1 at t=5 -> req_ready=0100
//    at t=5, rsp_valid=0100 at t=7, rsp_data=g_out.
//  3 Fairness: req_valid=1111 held, rnd_valid=1 -> grants 0001,0010,0100,1000,
//    0001 on consecutive cycles.
//  4 Randomness stall: req_valid=0011, rnd_valid toggles 1,0,1 -> grants
//    0001,0000,0010; rnd_ready=1,0,1; g_ina=0 in the stall cycle.
//  5 Wrap/skip: ptr=3, req_valid=0101 -> grant 0001, then 0100, then 0001.
//  6 Mux isolation: requester 2 ina=count*d bits 0xA5.., others 0 -> g_ina
//    equals slice 2 exactly; rsp_valid owner matches after LAT, for LAT=1..4.

Source files
------------

// File: rtl/msk_gadget_scheduler_pkg.sv
// Shared types and helpers for the masked-gadget scheduler.
// One-hot vectors are carried at the widest supported requester count.
package msk_gadget_scheduler_pkg;

  typedef logic [7:0] onehot_t;

  // Isolates the lowest set bit; zero in gives zero out.
  function automatic onehot_t lowest_set(input onehot_t v);
    return v & (~v + onehot_t'(1));
  endfunction

endpackage

// File: rtl/msk_gadget_scheduler_if.sv
// Requester, randomness, gadget and response signals of the scheduler.
// slave is the scheduler's view; master is the surrounding datapath's view.
interface msk_gadget_scheduler_if #(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int NREQ  = 4
);
  localparam int W = count * d;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_ina;
  logic [NREQ*W-1:0] req_inb;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [W-1:0]      g_ina;
  logic [W-1:0]      g_inb;
  logic [W-1:0]      g_out;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              busy;

  modport slave (
    input  req_valid, req_ina, req_inb, rnd_valid, g_out,
    output req_ready, rnd_ready, g_ina, g_inb, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_ina, req_inb, rnd_valid, g_out,
    input  req_ready, rnd_ready, g_ina, g_inb, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/msk_rr_arbiter.sv
// Round-robin arbiter with a one-hot pointer; grants the first request at or
// after the pointer, cyclically, and advances past the winner when enabled.
module msk_rr_arbiter
  import msk_gadget_scheduler_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

  logic [NREQ-1:0] ptr_reg;
  logic [NREQ-1:0] ptr_next;
  logic [NREQ-1:0] at_or_after;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick;

  always_comb begin
    // Thermometer of positions >= pointer; fall back to the full vector to wrap.
    at_or_after = ~(ptr_reg - NREQ'(1));
    masked      = req & at_or_after;
    cand        = (|masked) ? masked : req;
    pick        = NREQ'(lowest_set(onehot_t'(cand)));
    grant       = en ? pick : '0;
    ptr_next    = ptr_reg;
    if (en) begin
      ptr_next = {pick[NREQ-2:0], pick[NREQ-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= NREQ'(1);
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/msk_gadget_scheduler.sv
// Time-shares one fixed-latency masked gadget among NREQ requesters and routes
// each result back to its owner LAT cycles after issue.
module msk_gadget_scheduler
  import msk_gadget_scheduler_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1,
  parameter int NREQ  = 4,
  parameter int LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  msk_gadget_scheduler_if.slave  bus
);

  localparam int W = count * d;

  logic            issue;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    sel_a [NREQ];
  logic [W-1:0]    sel_b [NREQ];
  logic [W-1:0]    mux_a;
  logic [W-1:0]    mux_b;
  logic            tag_valid_reg [LAT];
  logic [NREQ-1:0] tag_owner_reg [LAT];
  logic [LAT-1:0]  tag_valid_vec;
  logic [NREQ-1:0] rsp_valid;

  // Held in reset, nothing may be granted or consume randomness.
  assign issue = rst_n & bus.rnd_valid & (|bus.req_valid);

  msk_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.req_valid),
    .en    (issue),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign bus.rnd_ready = issue;

  // Select is control-only; each share bit passes through its own AND-OR path.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
    assign sel_a[gi] = {W{grant[gi]}} & bus.req_ina[gi*W +: W];
    assign sel_b[gi] = {W{grant[gi]}} & bus.req_inb[gi*W +: W];
  end

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      mux_a = mux_a | sel_a[i];
      mux_b = mux_b | sel_b[i];
    end
  end

  assign bus.g_ina = mux_a;
  assign bus.g_inb = mux_b;

  // Tag pipe mirrors the gadget's internal registers stage for stage.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_owner_reg[gi] <= '0;
        end else begin
          tag_valid_reg[gi] <= issue;
          tag_owner_reg[gi] <= grant;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_owner_reg[gi] <= '0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_owner_reg[gi] <= tag_owner_reg[gi-1];
        end
      end
    end
    assign tag_valid_vec[gi] = tag_valid_reg[gi];
  end

  assign rsp_valid     = tag_valid_reg[LAT-1] ? tag_owner_reg[LAT-1] : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = (|rsp_valid) ? bus.g_out : '0;
  assign bus.busy      = |tag_valid_vec;

endmodule

// File: tb/tb_msk_gadget_scheduler.sv
// Directed bench: four schedulers (LAT=1..4) share one stimulus and are checked
// against hand-computed grants, responses and mux values.
module tb_msk_gadget_scheduler;

  localparam int NR = 4;
  localparam int DD = 4;
  localparam int CN = 2;
  localparam int W  = DD * CN;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_ina;
  logic [NR*W-1:0]   req_inb;
  logic              rnd_valid;
  logic [W-1:0]      g_out;

  logic [NR-1:0] ready_o  [4];
  logic          rndr_o   [4];
  logic [W-1:0]  gina_o   [4];
  logic [W-1:0]  ginb_o   [4];
  logic [NR-1:0] rspv_o   [4];
  logic [W-1:0]  rspd_o   [4];
  logic          busy_o   [4];

  int n_total = 0;
  int n_pass  = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    msk_gadget_scheduler_if #(.d(DD), .count(CN), .NREQ(NR)) u_if ();
    assign u_if.req_valid = req_valid;
    assign u_if.req_ina   = req_ina;
    assign u_if.req_inb   = req_inb;
    assign u_if.rnd_valid = rnd_valid;
    assign u_if.g_out     = g_out;
    assign ready_o[gi]    = u_if.req_ready;
    assign rndr_o[gi]     = u_if.rnd_ready;
    assign gina_o[gi]     = u_if.g_ina;
    assign ginb_o[gi]     = u_if.g_inb;
    assign rspv_o[gi]     = u_if.rsp_valid;
    assign rspd_o[gi]     = u_if.rsp_data;
    assign busy_o[gi]     = u_if.busy;

    msk_gadget_scheduler #(.d(DD), .count(CN), .NREQ(NR), .LAT(gi + 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rnd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [NR-1:0] exp_g4 [3];
  logic          exp_r4 [3];
  logic [W-1:0]  exp_a4 [3];
  logic [NR-1:0] exp_g5 [3];

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rnd_valid = 1'b1;
    req_ina   = {NR*W{1'b1}};
    req_inb   = {NR*W{1'b1}};
    g_out     = 8'h77;

    // Reset state with requests and randomness present
    #3;
    check("t1_rst_ready",   32'(ready_o[2]), 32'h0);
    check("t1_rst_rndrdy",  32'(rndr_o[2]),  32'h0);
    check("t1_rst_gina",    32'(gina_o[2]),  32'h0);
    check("t1_rst_rspv",    32'(rspv_o[2]),  32'h0);
    check("t1_rst_busy",    32'(busy_o[2]),  32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Two ops in flight on LAT=3, then reset mid-stream
    req_valid = 4'b0001;
    #2 check("t1_grant_a", 32'(ready_o[2]), 32'h1);
    tick();
    req_valid = 4'b0010;
    #2 check("t1_grant_b", 32'(ready_o[2]), 32'h2);
    tick();
    req_valid = '0;
    rnd_valid = 1'b0;
    #2 check("t1_busy_inflight", 32'(busy_o[2]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t1_busy_after_rst", 32'(busy_o[2]), 32'h0);
    check("t1_rspv_after_rst", 32'(rspv_o[2]), 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2 check($sformatf("t1_no_rsp_c%0d", c), 32'(rspv_o[2]), 32'h0);
      tick();
    end

    // Latency on LAT=2: accept at t, response at t+2
    do_reset();
    g_out     = 8'h5A;
    req_valid = 4'b0100;
    rnd_valid = 1'b1;
    #2;
    check("t2_ready_t",  32'(ready_o[1]), 32'h4);
    check("t2_rndrdy_t", 32'(rndr_o[1]),  32'h1);
    tick();
    req_valid = '0;
    rnd_valid = 1'b0;
    #2;
    check("t2_rspv_t1",     32'(rspv_o[1]), 32'h0);
    check("t2_rspv_lat1",   32'(rspv_o[0]), 32'h4);
    tick();
    #2;
    check("t2_rspv_t2",  32'(rspv_o[1]), 32'h4);
    check("t2_rspd_t2",  32'(rspd_o[1]), 32'h5A);
    tick();
    #2;
    check("t2_rspv_t3",  32'(rspv_o[1]), 32'h0);
    check("t2_rspd_t3",  32'(rspd_o[1]), 32'h0);

    // Fairness with all requesters active; LAT=1 echoes previous owner
    do_reset();
    req_valid = 4'b1111;
    rnd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      check($sformatf("t3_grant%0d", k), 32'(ready_o[0]), 32'(1 << (k % 4)));
      if (k > 0) check($sformatf("t3_rsp%0d", k), 32'(rspv_o[0]), 32'(1 << ((k - 1) % 4)));
      tick();
    end
    // Single requester every cycle, issue and response to it together
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("t3_solo_grant%0d", k), 32'(ready_o[0]), 32'h2);
      if (k > 0) check($sformatf("t3_solo_rsp%0d", k), 32'(rspv_o[0]), 32'h2);
      tick();
    end

    // Randomness stall
    do_reset();
    req_ina   = {8'h00, 8'h00, 8'h22, 8'h11};
    req_valid = 4'b0011;
    exp_g4 = '{4'b0001, 4'b0000, 4'b0010};
    exp_r4 = '{1'b1, 1'b0, 1'b1};
    exp_a4 = '{8'h11, 8'h00, 8'h22};
    for (int k = 0; k < 3; k++) begin
      rnd_valid = exp_r4[k];
      #2;
      check($sformatf("t4_grant%0d", k),  32'(ready_o[0]), 32'(exp_g4[k]));
      check($sformatf("t4_rndrdy%0d", k), 32'(rndr_o[0]),  32'(exp_r4[k]));
      check($sformatf("t4_gina%0d", k),   32'(gina_o[0]),  32'(exp_a4[k]));
      tick();
    end

    // Pointer wrap and skip: drive ptr to 3, then 0101
    do_reset();
    rnd_valid = 1'b1;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0101;
    exp_g5 = '{4'b0001, 4'b0100, 4'b0001};
    for (int k = 0; k < 3; k++) begin
      #2 check($sformatf("t5_grant%0d", k), 32'(ready_o[0]), 32'(exp_g5[k]));
      tick();
    end

    // Mux isolation and owner return for LAT=1..4
    do_reset();
    req_ina   = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_inb   = {8'hFF, 8'h3C, 8'hFF, 8'hFF};
    g_out     = 8'hC3;
    req_valid = 4'b0100;
    rnd_valid = 1'b1;
    #2;
    for (int l = 0; l < 4; l++) begin
      check($sformatf("t6_gina_lat%0d", l + 1), 32'(gina_o[l]), 32'hA5);
      check($sformatf("t6_ginb_lat%0d", l + 1), 32'(ginb_o[l]), 32'h3C);
    end
    tick();
    req_valid = '0;
    rnd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      if (c == 1) check("t6_gina_idle", 32'(gina_o[0]), 32'h0);
      for (int l = 0; l < 4; l++) begin
        check($sformatf("t6_rspv_lat%0d_c%0d", l + 1, c), 32'(rspv_o[l]),
              (c == l + 1) ? 32'h4 : 32'h0);
        check($sformatf("t6_rspd_lat%0d_c%0d", l + 1, c), 32'(rspd_o[l]),
              (c == l + 1) ? 32'hC3 : 32'h0);
      end
      check($sformatf("t6_busy_lat4_c%0d", c), 32'(busy_o[3]), (c < 4) ? 32'h1 : 32'h1);
      tick();
    end
    #2 check("t6_busy_lat4_done", 32'(busy_o[3]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
